dcache_axi_wr_master: RTL and testbench

Serialises one DCache write-back line (address + DCACHE_BLOCK_DW-bit block) into a single AXI4 INCR write burst of AXI_DW-bit beats, then collects the write response. Sits directly downstream of the main memory controller's DCache write path (`dcache_valid_wr` / `dcache_address_wr` / `dcache_data_wr`) for uncached/peripheral address windows. It replaces the combinational single-beat AW/W drive with a fully handshaked, registered burst master.

---
 rtl/dcache_axi_wr_master.sv | 114 +++++++++++
 tb/tb_dcache_axi_wr_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_axi_wr_master.sv
// Serialises one DCache write-back line into a single AXI4 INCR write burst and collects the B response.
// Optional B-channel watchdog is enabled by defining AXI_WR_TIMEOUT_EN.
module dcache_axi_wr_master #(
  parameter int DCACHE_BLOCK_DW = 256,
  parameter int AXI_DW          = 32,
  parameter int AXI_ID          = 1,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [31:0]                req_address_i,
  input  logic [DCACHE_BLOCK_DW-1:0] req_data_i,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                awaddr,
  output logic [3:0]                 awid,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       wvalid,
  input  logic                       wready,
  output logic [31:0]                wdata,
  output logic                       wlast,
  input  logic                       bvalid,
  output logic                       bready,
  input  logic [3:0]                 bid,
  input  logic [1:0]                 bresp
);

  localparam int BEATS    = DCACHE_BLOCK_DW / AXI_DW;
  localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS = $clog2(DCACHE_BLOCK_DW / 8);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              beat_q;
  logic [31:0]                addr_q;
  logic [DCACHE_BLOCK_DW-1:0] data_q;
  logic                       done_q, err_q;
  logic                       tmo_hit;
  logic                       resp_bad;

`ifdef AXI_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Counts cycles spent in RESP; cleared whenever the FSM is anywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else if (state_q == RESP) tmo_q <= tmo_q + 1'b1;
    else tmo_q <= '0;
  end
  assign tmo_hit = (state_q == RESP) && !bvalid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign resp_bad = (bresp inside {2'b10, 2'b11}) || (bid != 4'(AXI_ID));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = ADDR;
      ADDR: if (awready) state_d = DATA;
      DATA: if (wready && (beat_q == LAST_BEAT)) state_d = RESP;
      RESP: if (bvalid || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == RESP) && (bvalid || tmo_hit);
      err_q   <= (state_q == RESP) && ((bvalid && resp_bad) || tmo_hit);
      if (state_q == IDLE && req_valid_i) begin
        addr_q <= req_address_i & ADDR_MASK;
        data_q <= req_data_i;
        beat_q <= '0;
      end else if (state_q == DATA && wready) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign awvalid     = (state_q == ADDR);
  assign wvalid      = (state_q == DATA);
  assign bready      = (state_q == RESP);
  assign wlast       = (state_q == DATA) && (beat_q == LAST_BEAT);
  assign awaddr      = addr_q;
  assign wdata       = data_q[beat_q*AXI_DW +: AXI_DW];
  assign awid        = 4'(AXI_ID);
  assign awlen       = 8'(BEATS - 1);
  assign awsize      = 3'b010;
  assign awburst     = 2'b01;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dcache_axi_wr_master.sv
// Self-checking bench for dcache_axi_wr_master: vector table, random bursts, reset and timeout corners.
module tb_dcache_axi_wr_master;

  localparam int DW  = 256;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [31:0]   req_address_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic          done_o, err_o;
  logic          awvalid, awready = 1'b0;
  logic [31:0]   awaddr;
  logic [3:0]    awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          wvalid, wready = 1'b0;
  logic [31:0]   wdata;
  logic          wlast;
  logic          bvalid = 1'b0, bready;
  logic [3:0]    bid = 4'd1;
  logic [1:0]    bresp = 2'b00;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dcache_axi_wr_master #(
    .DCACHE_BLOCK_DW(DW), .AXI_DW(32), .AXI_ID(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_address_i(req_address_i), .req_data_i(req_data_i),
    .done_o(done_o), .err_o(err_o),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  typedef struct {
    logic [31:0] addr;
    bit          rnd;
    int          aw_stall;
    logic [31:0] wmask;
    int          b_delay;
    bit          b_early;
    logic [1:0]  bresp;
    logic [3:0]  bid;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Drives one request, plays the slave side, and compares against expectations
  // derived directly from the burst rules (cycle arithmetic, beat list, response code).
  task automatic run_burst(input vec_t v);
    logic [DW-1:0] data;
    logic [31:0]   exp_addr;
    int nw, ones, exp_resp, exp_done, cyc, aw_cnt, beat, wc, rcnt, done_cyc;
    bit exp_err, aw_done, b_done, early_w, addr_bad, data_bad, wlast_bad, got_done;
    logic got_err, got_rdy;

    for (int i = 0; i < 8; i++) data[i*32 +: 32] = v.rnd ? $urandom : 32'hA5A5_0000 + i;
    exp_addr = {v.addr[31:5], 5'b0};
    ones = 0; nw = 0;
    while (ones < 8) begin
      if (nw >= 32 || v.wmask[nw]) ones++;
      nw++;
    end
    exp_resp = 2 + v.aw_stall + nw;
    exp_err  = v.bresp[1] || (v.bid != 4'd1);
    exp_done = exp_resp + 1 + (v.b_early ? 0 : v.b_delay);
`ifdef AXI_WR_TIMEOUT_EN
    if (!v.b_early && v.b_delay >= TMO) begin
      exp_done = exp_resp + TMO;
      exp_err  = 1'b1;
    end
`endif
    aw_cnt = 0; beat = 0; wc = 0; rcnt = 0; done_cyc = -1;
    aw_done = 0; b_done = 0; early_w = 0; addr_bad = 0; data_bad = 0; wlast_bad = 0;
    got_done = 0; got_err = 1'bx; got_rdy = 1'bx;

    @(negedge clk);
    chk("req_ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_address_i = v.addr; req_data_i = data;
    bresp = v.bresp; bid = v.bid;
    bvalid = v.b_early;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (cyc = 1; cyc < 300 && !got_done; cyc++) begin
      if (done_o) begin got_done = 1; done_cyc = cyc; got_err = err_o; got_rdy = req_ready_o; end
      if (awvalid) begin
        aw_cnt++;
        if (awaddr !== exp_addr) addr_bad = 1;
      end
      if (wvalid && !aw_done) early_w = 1;
      awready = awvalid && (aw_cnt > v.aw_stall);
      if (awready) aw_done = 1;
      if (wvalid) begin
        if (beat > 7 || wdata !== data[beat*32 +: 32]) data_bad = 1;
        if (wlast !== (beat == 7)) wlast_bad = 1;
        wready = (wc >= 32) || v.wmask[wc];
        wc++;
        if (wready) beat++;
      end else begin
        wready = 1'b0;
        if (wlast !== 1'b0) wlast_bad = 1;
      end
      if (bready) rcnt++;
      if (v.b_early) bvalid = !b_done;
      else bvalid = bready && (rcnt > v.b_delay);
      if (bready && bvalid) b_done = 1;
      @(negedge clk);
    end
    awready = 0; wready = 0; bvalid = 0;
    if (!got_done) $display("FAIL done_timeout: no done_o within %0d cycles", cyc);
    chk("done_cycle", done_cyc, exp_done);
    chk("err", got_err, exp_err);
    chk("req_ready_at_done", got_rdy, 1'b1);
    chk("done_one_pulse", done_o, 1'b0);
    chk("aw_cycles", aw_cnt, v.aw_stall + 1);
    chk("awaddr_stable", addr_bad, 1'b0);
    chk("no_w_before_aw", early_w, 1'b0);
    chk("beat_count", beat, 8);
    chk("wdata_order", data_bad, 1'b0);
    chk("wlast_only_last", wlast_bad, 1'b0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{32'h3000_0044, 0, 0, 32'hFFFF_FFFF, 0, 0, 2'b00, 4'd1};
    tbl[1] = '{32'h3000_0044, 0, 3, 32'hFFFF_FFFF, 0, 0, 2'b00, 4'd1};
    tbl[2] = '{32'h3000_0044, 0, 0, 32'h5555_5555, 0, 0, 2'b00, 4'd1};
    tbl[3] = '{32'h1234_5678, 1, 0, 32'hFFFF_FFFF, 0, 0, 2'b10, 4'd1};
    tbl[4] = '{32'h1234_56A0, 1, 0, 32'hFFFF_FFFF, 0, 0, 2'b00, 4'd0};
    tbl[5] = '{32'h8000_001C, 1, 0, 32'hFFFF_FFFF, 0, 1, 2'b00, 4'd1};
    tbl[6] = '{32'hFFFF_FFFF, 1, 2, 32'h0F0F_0F0F, 3, 0, 2'b11, 4'd1};

    #12;
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_done_err", {done_o, err_o}, 2'b00);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("awlen", awlen, 8'd7);
    chk("aw_consts", {awid, awsize, awburst}, {4'd1, 3'b010, 2'b01});

    for (int t = 0; t < 7; t++) run_burst(tbl[t]);

    for (int r = 0; r < 20; r++) begin
      rv.addr     = $urandom;
      rv.rnd      = 1;
      rv.aw_stall = int'($urandom_range(0, 3));
      rv.wmask    = $urandom;
      rv.b_delay  = int'($urandom_range(0, 4));
      rv.b_early  = ($urandom_range(0, 3) == 0);
      rv.bresp    = 2'($urandom);
      rv.bid      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd1;
      run_burst(rv);
    end

    // Reset while beat 4 is on the W channel, then a fresh burst from beat 0.
    @(negedge clk);
    req_valid_i = 1'b1; req_address_i = 32'h4000_0000;
    for (int i = 0; i < 8; i++) req_data_i[i*32 +: 32] = 32'hBEEF_0000 + i;
    @(negedge clk);
    req_valid_i = 1'b0; awready = 1'b1; wready = 1'b1;
    repeat (5) @(negedge clk);
    chk("beat4_wdata", wdata, 32'hBEEF_0004);
    rst_n = 1'b0;
    #1;
    chk("midrst_wvalid", wvalid, 1'b0);
    chk("midrst_awvalid", awvalid, 1'b0);
    chk("midrst_req_ready", req_ready_o, 1'b1);
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("midrst_wvalid_next", wvalid, 1'b0);
    rst_n = 1'b1;
    run_burst(tbl[0]);

`ifdef AXI_WR_TIMEOUT_EN
    rv = '{32'h5000_0000, 1, 0, 32'hFFFF_FFFF, 100000, 0, 2'b00, 4'd1};
    run_burst(rv);
    run_burst(tbl[0]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
